// File: rtl/core_pkg.sv
// Shared constants and helpers for the RV32I write-back stage:
// retire kinds, load funct3 codes, FSM state encoding and extension helpers.
package core_pkg;

   localparam logic [2:0] WB_KIND_NONE  = 3'd0;
   localparam logic [2:0] WB_KIND_ALU   = 3'd1;
   localparam logic [2:0] WB_KIND_LINK  = 3'd2;
   localparam logic [2:0] WB_KIND_LUI   = 3'd3;
   localparam logic [2:0] WB_KIND_AUIPC = 3'd4;
   localparam logic [2:0] WB_KIND_LOAD  = 3'd5;

   localparam logic [2:0] LOAD_F3_LB  = 3'b000;
   localparam logic [2:0] LOAD_F3_LH  = 3'b001;
   localparam logic [2:0] LOAD_F3_LW  = 3'b010;
   localparam logic [2:0] LOAD_F3_LBU = 3'b100;
   localparam logic [2:0] LOAD_F3_LHU = 3'b101;

   typedef enum logic [0:0] {
      WB_ST_IDLE      = 1'b0,
      WB_ST_WAIT_LOAD = 1'b1
   } wb_state_e;

   function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
      return {{24{sgn & b[7]}}, b};
   endfunction

   function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
      return {{16{sgn & h[15]}}, h};
   endfunction

endpackage

// File: rtl/core_load_align.sv
// Combinational load formatter: picks the addressed byte/half/word out of the
// raw read word, extends it, and flags misaligned or unsupported accesses.
module core_load_align
   import core_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr,
   input  logic [31:0] rdata,
   output logic [31:0] data,
   output logic        misaligned,
   output logic        unsupported
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   assign byte_s = rdata[{addr, 3'b000} +: 8];
   assign half_s = addr[1] ? rdata[31:16] : rdata[15:0];

   // Width/sign decode of the load
   always_comb begin
      data        = 32'd0;
      misaligned  = 1'b0;
      unsupported = 1'b0;
      case (funct3)
         LOAD_F3_LB:  data = ext_byte(byte_s, 1'b1);
         LOAD_F3_LBU: data = ext_byte(byte_s, 1'b0);
         LOAD_F3_LH: begin
            data       = ext_half(half_s, 1'b1);
            misaligned = addr[0];
         end
         LOAD_F3_LHU: begin
            data       = ext_half(half_s, 1'b0);
            misaligned = addr[0];
         end
         LOAD_F3_LW: begin
            data       = rdata;
            misaligned = (addr != 2'b00);
         end
         default: unsupported = 1'b1;
      endcase
   end

endmodule

// File: rtl/core_wb_stage.sv
// Registered RV32I write-back stage: accepts one retiring instruction per
// handshake, waits on data-memory reads and drives a registered RF write port.
module core_wb_stage
   import core_pkg::*;
#(
   parameter int               XLEN          = 32,
   parameter int               LOAD_TIMEOUT  = 15,
   parameter logic [XLEN-1:0]  ILLEGAL_VALUE = 32'hDEADBEEF
) (
   input  logic            CLK,
   input  logic            NRST,
   input  logic            IN_VALID,
   output logic            IN_READY,
   input  logic [2:0]      IN_KIND,
   input  logic [XLEN-1:0] IN_ALU_O,
   input  logic [XLEN-1:0] IN_PC,
   input  logic [XLEN-1:0] IN_IMM,
   input  logic [4:0]      IN_RD,
   input  logic [2:0]      IN_FUNCT3,
   input  logic            DMEM_RVALID,
   input  logic [XLEN-1:0] DMEM_RDATA,
   output logic            REG_WE,
   output logic [4:0]      REG_WADDR,
   output logic [XLEN-1:0] REG_WDATA,
   output logic            LOAD_TIMEOUT_ERR
);

   localparam int             CNT_W       = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
   localparam int             TO_LAST_INT = (LOAD_TIMEOUT > 0) ? (LOAD_TIMEOUT - 1) : 0;
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_LAST_INT);
   localparam logic           TO_EN       = (LOAD_TIMEOUT > 0);

   wb_state_e        state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             reg_we_r, reg_we_s;
   logic [4:0]       reg_waddr_r, reg_waddr_s;
   logic [XLEN-1:0]  reg_wdata_r, reg_wdata_s;
   logic             err_r, err_s;
   logic             accept_s;

   logic [4:0]       rd_r;
   logic [2:0]       funct3_r;
   logic [1:0]       addr_r;

   logic [XLEN-1:0]  result_s;
   logic [XLEN-1:0]  aligned_s;
   logic             misaligned_s;
   logic             unsupported_s;
   logic [XLEN-1:0]  load_wdata_s;

   assign IN_READY = (state_r == WB_ST_IDLE);
   assign accept_s = IN_VALID & IN_READY;

   core_load_align u_align (
      .funct3      (funct3_r),
      .addr        (addr_r),
      .rdata       (DMEM_RDATA),
      .data        (aligned_s),
      .misaligned  (misaligned_s),
      .unsupported (unsupported_s)
   );

   assign load_wdata_s = (misaligned_s | unsupported_s) ? ILLEGAL_VALUE : aligned_s;

   // Write data for non-load kinds, taken straight from the incoming entry
   always_comb begin
      result_s = ILLEGAL_VALUE;
      case (IN_KIND)
         WB_KIND_ALU:   result_s = IN_ALU_O;
         WB_KIND_LINK:  result_s = IN_PC + XLEN'(4);
         WB_KIND_LUI:   result_s = IN_IMM;
         WB_KIND_AUIPC: result_s = IN_PC + IN_IMM;
         default:       result_s = ILLEGAL_VALUE;
      endcase
   end

   // Next-state, timeout counter and next register-file write
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      reg_we_s    = 1'b0;
      reg_waddr_s = reg_waddr_r;
      reg_wdata_s = reg_wdata_r;
      err_s       = 1'b0;
      case (state_r)
         WB_ST_IDLE: begin
            if (accept_s) begin
               if (IN_KIND == WB_KIND_LOAD) begin
                  state_s = WB_ST_WAIT_LOAD;
                  cnt_s   = '0;
               end else if (IN_KIND != WB_KIND_NONE) begin
                  reg_we_s    = (IN_RD != 5'd0);
                  reg_waddr_s = IN_RD;
                  reg_wdata_s = result_s;
               end else begin
                  state_s = WB_ST_IDLE;
               end
            end else begin
               state_s = WB_ST_IDLE;
            end
         end
         WB_ST_WAIT_LOAD: begin
            // Read data has priority over an expiring timeout in the same cycle
            if (DMEM_RVALID) begin
               reg_we_s    = (rd_r != 5'd0);
               reg_waddr_s = rd_r;
               reg_wdata_s = load_wdata_s;
               state_s     = WB_ST_IDLE;
               cnt_s       = '0;
            end else if (TO_EN && (cnt_r == TO_LAST)) begin
               err_s   = 1'b1;
               state_s = WB_ST_IDLE;
               cnt_s   = '0;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            state_s = WB_ST_IDLE;
            cnt_s   = '0;
         end
      endcase
   end

   // State, counter, latched entry fields and registered write port
   always_ff @(posedge CLK) begin
      if (!NRST) begin
         state_r     <= WB_ST_IDLE;
         cnt_r       <= '0;
         reg_we_r    <= 1'b0;
         reg_waddr_r <= 5'd0;
         reg_wdata_r <= '0;
         err_r       <= 1'b0;
         rd_r        <= 5'd0;
         funct3_r    <= 3'd0;
         addr_r      <= 2'd0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         reg_we_r    <= reg_we_s;
         reg_waddr_r <= reg_waddr_s;
         reg_wdata_r <= reg_wdata_s;
         err_r       <= err_s;
         if (accept_s) begin
            rd_r     <= IN_RD;
            funct3_r <= IN_FUNCT3;
            addr_r   <= IN_ALU_O[1:0];
         end else begin
            rd_r     <= rd_r;
            funct3_r <= funct3_r;
            addr_r   <= addr_r;
         end
      end
   end

   assign REG_WE           = reg_we_r;
   assign REG_WADDR        = reg_waddr_r;
   assign REG_WDATA        = reg_wdata_r;
   assign LOAD_TIMEOUT_ERR = err_r;

endmodule

// File: tb/tb_core_wb_stage.sv
// Directed and randomized bench for core_wb_stage with a behavioural model.
module tb_core_wb_stage;

   localparam logic [31:0] ILL = 32'hDEADBEEF;

   logic        CLK;
   logic        NRST;
   logic        IN_VALID;
   logic        IN_READY;
   logic [2:0]  IN_KIND;
   logic [31:0] IN_ALU_O;
   logic [31:0] IN_PC;
   logic [31:0] IN_IMM;
   logic [4:0]  IN_RD;
   logic [2:0]  IN_FUNCT3;
   logic        DMEM_RVALID;
   logic [31:0] DMEM_RDATA;
   logic        REG_WE;
   logic [4:0]  REG_WADDR;
   logic [31:0] REG_WDATA;
   logic        LOAD_TIMEOUT_ERR;

   int n_chk = 0;
   int n_err = 0;
   logic [4:0]  exp_waddr;
   logic [31:0] exp_wdata;

   core_wb_stage #(.XLEN(32), .LOAD_TIMEOUT(15), .ILLEGAL_VALUE(32'hDEADBEEF)) dut (
      .CLK(CLK), .NRST(NRST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .IN_KIND(IN_KIND), .IN_ALU_O(IN_ALU_O), .IN_PC(IN_PC), .IN_IMM(IN_IMM),
      .IN_RD(IN_RD), .IN_FUNCT3(IN_FUNCT3), .DMEM_RVALID(DMEM_RVALID),
      .DMEM_RDATA(DMEM_RDATA), .REG_WE(REG_WE), .REG_WADDR(REG_WADDR),
      .REG_WDATA(REG_WDATA), .LOAD_TIMEOUT_ERR(LOAD_TIMEOUT_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Behavioural write-data model from the kind/load rules
   function automatic logic [31:0] model_data(input logic [2:0] kind, input logic [31:0] alu,
                                              input logic [31:0] pc, input logic [31:0] imm,
                                              input logic [2:0] f3, input logic [31:0] rdata);
      int a;
      logic [31:0] v;
      a = int'(alu % 32'd4);
      case (kind)
         3'd1: return alu;
         3'd2: return pc + 32'd4;
         3'd3: return imm;
         3'd4: return pc + imm;
         3'd5: begin
            if (f3 == 3'd0 || f3 == 3'd4) begin
               v = (rdata >> (8 * a)) & 32'hFF;
               if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
               return v;
            end else if (f3 == 3'd1 || f3 == 3'd5) begin
               if (a % 2 != 0) return ILL;
               v = (rdata >> (8 * a)) & 32'hFFFF;
               if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
               return v;
            end else if (f3 == 3'd2) begin
               if (a != 0) return ILL;
               return rdata;
            end else begin
               return ILL;
            end
         end
         default: return ILL;
      endcase
   endfunction

   task automatic drive(input logic [2:0] kind, input logic [31:0] alu, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [4:0] rd, input logic [2:0] f3);
      IN_VALID  = 1'b1;
      IN_KIND   = kind;
      IN_ALU_O  = alu;
      IN_PC     = pc;
      IN_IMM    = imm;
      IN_RD     = rd;
      IN_FUNCT3 = f3;
   endtask

   task automatic run_nonload(input string tag, input logic [2:0] kind, input logic [31:0] alu,
                              input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd);
      drive(kind, alu, pc, imm, rd, 3'd0);
      step();
      if (kind != 3'd0) begin
         exp_waddr = rd;
         exp_wdata = model_data(kind, alu, pc, imm, 3'd0, 32'd0);
      end
      chk({tag, "_we"}, REG_WE, ((kind != 3'd0) && (rd != 5'd0)) ? 32'd1 : 32'd0);
      chk({tag, "_waddr"}, REG_WADDR, exp_waddr);
      chk({tag, "_wdata"}, REG_WDATA, exp_wdata);
      chk({tag, "_ready"}, IN_READY, 32'd1);
   endtask

   task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] rdata, input int lat);
      drive(3'd5, addr, $urandom, $urandom, rd, f3);
      step();
      IN_VALID = 1'b0;
      chk({tag, "_we_accept"}, REG_WE, 32'd0);
      for (int i = 0; i < lat; i++) begin
         chk({tag, "_ready_wait"}, IN_READY, 32'd0);
         DMEM_RVALID = (i == lat - 1);
         DMEM_RDATA  = (i == lat - 1) ? rdata : $urandom;
         step();
      end
      DMEM_RVALID = 1'b0;
      exp_waddr = rd;
      exp_wdata = model_data(3'd5, addr, 32'd0, 32'd0, f3, rdata);
      chk({tag, "_we"}, REG_WE, (rd != 5'd0) ? 32'd1 : 32'd0);
      chk({tag, "_waddr"}, REG_WADDR, exp_waddr);
      chk({tag, "_wdata"}, REG_WDATA, exp_wdata);
      chk({tag, "_err"}, LOAD_TIMEOUT_ERR, 32'd0);
      chk({tag, "_ready"}, IN_READY, 32'd1);
   endtask

   initial begin
      logic [2:0] kind;
      logic [2:0] f3;
      logic [4:0] rd;
      logic [2:0] f3_tab [8];
      f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

      NRST = 1'b0; IN_VALID = 1'b0; IN_KIND = 3'd0; IN_ALU_O = 32'd0; IN_PC = 32'd0;
      IN_IMM = 32'd0; IN_RD = 5'd0; IN_FUNCT3 = 3'd0; DMEM_RVALID = 1'b0; DMEM_RDATA = 32'd0;
      step();
      step();
      chk("rst_we", REG_WE, 32'd0);
      chk("rst_waddr", REG_WADDR, 32'd0);
      chk("rst_wdata", REG_WDATA, 32'd0);
      chk("rst_err", LOAD_TIMEOUT_ERR, 32'd0);
      chk("rst_ready", IN_READY, 32'd1);
      NRST = 1'b1;
      exp_waddr = 5'd0;
      exp_wdata = 32'd0;

      // ALU write, then hold
      drive(3'd1, 32'h1234_5678, 32'd0, 32'd0, 5'd5, 3'd0);
      step();
      chk("alu_we", REG_WE, 32'd1);
      chk("alu_waddr", REG_WADDR, 32'd5);
      chk("alu_wdata", REG_WDATA, 32'h1234_5678);
      chk("alu_ready", IN_READY, 32'd1);
      IN_VALID = 1'b0;
      step();
      chk("hold_we", REG_WE, 32'd0);
      chk("hold_wdata", REG_WDATA, 32'h1234_5678);

      // LINK then AUIPC back-to-back
      drive(3'd2, 32'd0, 32'h100, 32'd0, 5'd1, 3'd0);
      step();
      chk("link_we", REG_WE, 32'd1);
      chk("link_wdata", REG_WDATA, 32'h104);
      drive(3'd4, 32'd0, 32'h200, 32'h1000, 5'd2, 3'd0);
      step();
      chk("auipc_we", REG_WE, 32'd1);
      chk("auipc_waddr", REG_WADDR, 32'd2);
      chk("auipc_wdata", REG_WDATA, 32'h1200);
      IN_VALID = 1'b0;
      step();
      chk("b2b_we_drop", REG_WE, 32'd0);

      // Sub-word and misaligned loads
      run_load("lb", 3'd0, 32'h0000_1003, 5'd7, 32'h80FF_0000, 3);
      chk("lb_value", REG_WDATA, 32'hFFFF_FF80);
      run_load("lbu", 3'd4, 32'h0000_1003, 5'd7, 32'h80FF_0000, 3);
      chk("lbu_value", REG_WDATA, 32'h0000_0080);
      run_load("lw_mis", 3'd2, 32'h0000_2002, 5'd8, 32'h1111_2222, 1);
      chk("lw_mis_value", REG_WDATA, 32'hDEAD_BEEF);
      run_load("lh", 3'd1, 32'h0000_2002, 5'd9, 32'h8001_0000, 2);
      chk("lh_value", REG_WDATA, 32'hFFFF_8001);

      // Load timeout
      drive(3'd5, 32'h40, 32'd0, 32'd0, 5'd10, 3'd2);
      step();
      IN_VALID = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         chk("to_ready_wait", IN_READY, 32'd0);
         chk("to_err_early", LOAD_TIMEOUT_ERR, 32'd0);
         step();
      end
      chk("to_err", LOAD_TIMEOUT_ERR, 32'd1);
      chk("to_we", REG_WE, 32'd0);
      chk("to_ready", IN_READY, 32'd1);
      step();
      chk("to_err_pulse", LOAD_TIMEOUT_ERR, 32'd0);

      // Read data arriving on the last timeout cycle wins
      drive(3'd5, 32'h44, 32'd0, 32'd0, 5'd11, 3'd2);
      step();
      IN_VALID = 1'b0;
      for (int k = 1; k <= 14; k++) step();
      DMEM_RVALID = 1'b1;
      DMEM_RDATA  = 32'hCAFE_F00D;
      step();
      DMEM_RVALID = 1'b0;
      chk("race_we", REG_WE, 32'd1);
      chk("race_wdata", REG_WDATA, 32'hCAFE_F00D);
      chk("race_err", LOAD_TIMEOUT_ERR, 32'd0);

      // RD=0 suppresses the write but still updates data/address
      drive(3'd1, 32'hA5A5_0001, 32'd0, 32'd0, 5'd0, 3'd0);
      step();
      IN_VALID = 1'b0;
      chk("rd0_we", REG_WE, 32'd0);
      chk("rd0_waddr", REG_WADDR, 32'd0);
      chk("rd0_wdata", REG_WDATA, 32'hA5A5_0001);

      // Reset in the middle of a load
      drive(3'd5, 32'h80, 32'd0, 32'd0, 5'd12, 3'd2);
      step();
      IN_VALID = 1'b0;
      step();
      NRST = 1'b0;
      step();
      NRST = 1'b1;
      chk("mrst_ready", IN_READY, 32'd1);
      chk("mrst_wdata", REG_WDATA, 32'd0);
      DMEM_RVALID = 1'b1;
      DMEM_RDATA  = 32'h7777_7777;
      step();
      DMEM_RVALID = 1'b0;
      chk("mrst_no_we", REG_WE, 32'd0);
      chk("mrst_no_wdata", REG_WDATA, 32'd0);
      exp_waddr = 5'd0;
      exp_wdata = 32'd0;

      // Random mix against the model
      for (int t = 0; t < 200; t++) begin
         kind = 3'($urandom_range(0, 7));
         rd   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         f3   = f3_tab[$urandom_range(0, 7)];
         if ($urandom_range(0, 3) == 0) begin
            IN_VALID    = 1'b0;
            DMEM_RVALID = $urandom_range(0, 1) == 1;
            step();
            DMEM_RVALID = 1'b0;
            chk("rnd_idle_we", REG_WE, 32'd0);
         end
         if (kind == 3'd5)
            run_load("rnd_load", f3, $urandom, rd, $urandom, $urandom_range(1, 6));
         else
            run_nonload("rnd_op", kind, $urandom, $urandom, $urandom, rd);
      end
      IN_VALID = 1'b0;
      step();
      chk("end_we", REG_WE, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/core_wb_stage.md
Name: core_wb_stage

Overview:
Parametrised write-back stage for the RV32I pipeline. It replaces the purely combinational WB mux with a registered stage that does four things: accepts one retiring instruction per handshake, waits on variable-latency data-memory reads, aligns and sign-extends sub-word loads, and drives a registered register-file write port. It sits between the MEM/WB boundary and the register file, and back-pressures MEM while a load is outstanding.

Parameters:
XLEN, 32, datapath width; only 32 is supported for RV32I.
LOAD_TIMEOUT, 15, cycles to wait for DMEM_RVALID before aborting; 0 disables the timeout.
ILLEGAL_VALUE, 32'hDEADBEEF, data written for reserved kinds and misaligned loads.

Ports:
CLK  in  1  clock; all state updates on its rising edge.
NRST  in  1  synchronous active-low reset.
IN_VALID  in  1  MEM/WB entry valid.
IN_READY  out  1  stage can accept an entry.
IN_KIND  in  3  0 NONE, 1 ALU, 2 LINK (jal/jalr), 3 LUI, 4 AUIPC, 5 LOAD, 6-7 reserved.
IN_ALU_O  in  XLEN  ALU result; for LOAD this is the byte address.
IN_PC  in  XLEN  instruction PC.
IN_IMM  in  XLEN  decoded immediate.
IN_RD  in  5  destination register.
IN_FUNCT3  in  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
DMEM_RVALID  in  1  read data valid.
DMEM_RDATA  in  XLEN  raw word read data.
REG_WE  out  1  registered write enable.
REG_WADDR  out  5  registered write address.
REG_WDATA  out  XLEN  registered write data.
LOAD_TIMEOUT_ERR  out  1  one-cycle pulse on load abort.

Behaviour:
- Reset (NRST=0 at a CLK edge):
  - state=IDLE, timeout counter=0.
  - REG_WE=0, REG_WADDR=0, REG_WDATA=0, LOAD_TIMEOUT_ERR=0.
  - Reset mid-load drops the pending load; no write occurs.
- States: IDLE, WAIT_LOAD.
- IN_READY=1 only in IDLE; it is combinational from state.
- Accept = IN_VALID & IN_READY. All IN_* fields are latched on accept.
- Non-load accept: the write appears on REG_* at the next edge (1-cycle latency) and the stage stays in IDLE. Data:
  - ALU: IN_ALU_O.
  - LINK: IN_PC+4.
  - LUI: IN_IMM.
  - AUIPC: IN_PC+IN_IMM.
  - Reserved (6-7): ILLEGAL_VALUE.
  - NONE: REG_WE=0.
  - All sums wrap modulo 2^XLEN.
- LOAD accept: go to WAIT_LOAD, counter=0, and no write in that cycle.
- WAIT_LOAD with DMEM_RVALID=1: at the next edge, write the formatted data and return to IDLE. This is 1 cycle after RVALID and minimum 2 cycles after accept.
- Load formatting uses the latched address a=ALU_O[1:0]:
  - LB/LBU: byte a, sign- or zero-extended.
  - LH/LHU: half a[1], extended; if a[0]=1 the load is misaligned.
  - LW: full word; if a!=0 the load is misaligned.
  - Misaligned or unsupported funct3 writes ILLEGAL_VALUE.
- WAIT_LOAD with DMEM_RVALID=0: the counter increments. When counter==LOAD_TIMEOUT-1 and LOAD_TIMEOUT>0:
  - next edge: LOAD_TIMEOUT_ERR=1 for one cycle, REG_WE=0, return to IDLE.
  - If RVALID arrives in that same cycle, RVALID wins (normal write, no error).
- DMEM_RVALID in IDLE is ignored.
- If the latched RD==0, REG_WE is forced to 0; data/address still update.
- REG_WE is high for exactly one cycle per write. Between writes, REG_WE=0 and REG_WADDR/REG_WDATA hold their last values.
- Back-to-back non-load entries sustain 1 write/cycle.

Decomposition:
- Package core_pkg holds:
  - WB_KIND_* constants.
  - LOAD_F3_* funct3 constants.
  - State encoding localparams.
- Sub-module core_load_align, purely combinational:
  - inputs: funct3, addr[1:0], rdata.
  - outputs: aligned data, misaligned flag.
- FSM, counter and result mux stay in core_wb_stage.

Test Plan:
- ALU kind, ALU_O=0x12345678, RD=5 -> next edge REG_WE=1, WADDR=5, WDATA=0x12345678; IN_READY stays 1.
- LINK with PC=0x100, then AUIPC with PC=0x200, IMM=0x1000, back-to-back -> writes 0x104 then 0x1200 on consecutive cycles.
- LB at addr 0x...3, RDATA=0x80FF_0000, RVALID after 3 cycles -> IN_READY=0 for 3 cycles, then WDATA=0xFFFFFF80; LBU gives 0x00000080.
- LW at addr 0x...2 -> WDATA=0xDEADBEEF; LH at addr 0x...2, RDATA=0x8001_0000 -> WDATA=0xFFFF8001.
- LOAD, RVALID never asserted, LOAD_TIMEOUT=15 -> after 15 wait cycles, LOAD_TIMEOUT_ERR pulses 1 cycle, REG_WE=0, IN_READY returns to 1.
- RD=0 with ALU kind -> REG_WE stays 0; NRST low during WAIT_LOAD -> IDLE, no write when RVALID arrives later.
